id_ex_stage: RTL

Pipeline register between decode and the execute-stage ALU. Captures one decoded instruction per handshake and resolves operand forwarding from the MEM and WB stages. Detects load-use hazards and inserts bubbles. Drives the ALU operand and control inputs directly, and passes destination and control bits on to the EX/MEM register.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/ex_forward_unit.sv | 66 ++++++
 rtl/id_ex_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared widths, ALU opcodes and ID/EX field layout.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_MUL = 4'b0110,
        ALU_XOR = 4'b0111,
        ALU_SLT = 4'b1000
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic            use_imm;
        logic [3:0]      alu_control;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } idex_t;

    // A producer can only supply a source register it actually writes; x0 is hardwired.
    function automatic logic src_hit(input logic en, input logic [RA_W-1:0] rd,
                                     input logic [RA_W-1:0] src);
        return en && (rd == src) && (src != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_forward_unit
// Purpose  : Operand forwarding selects/data and load-use hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module ex_forward_unit
    import alu_pkg::*;
(
    input  logic            valid,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            use_imm,
    input  logic            mem_write,
    input  logic            mem_fwd_en,
    input  logic            mem_fwd_is_load,
    input  logic [RA_W-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_en,
    input  logic [RA_W-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output fwd_sel_e        rs1_sel,
    output fwd_sel_e        rs2_sel,
    output logic [XLEN-1:0] rs1_fwd,
    output logic [XLEN-1:0] rs2_fwd,
    output logic            hazard
);

    logic mem_alu_en;
    logic load_pending;

    always_comb begin
        // Load data is not available in MEM; only ALU results forward from there.
        mem_alu_en   = mem_fwd_en & ~mem_fwd_is_load;
        load_pending = valid & mem_fwd_en & mem_fwd_is_load & (mem_fwd_rd != '0);

        rs1_sel = FWD_NONE;
        rs1_fwd = rs1_val;
        if (src_hit(mem_alu_en, mem_fwd_rd, rs1)) begin
            rs1_sel = FWD_MEM;
            rs1_fwd = mem_fwd_data;
        end else if (src_hit(wb_fwd_en, wb_fwd_rd, rs1)) begin
            rs1_sel = FWD_WB;
            rs1_fwd = wb_fwd_data;
        end

        rs2_sel = FWD_NONE;
        rs2_fwd = rs2_val;
        if (src_hit(mem_alu_en, mem_fwd_rd, rs2)) begin
            rs2_sel = FWD_MEM;
            rs2_fwd = mem_fwd_data;
        end else if (src_hit(wb_fwd_en, wb_fwd_rd, rs2)) begin
            rs2_sel = FWD_WB;
            rs2_fwd = wb_fwd_data;
        end

        // rs2 matters when it feeds the ALU or supplies store data.
        hazard = load_pending &
                 ((mem_fwd_rd == rs1) |
                  ((mem_fwd_rd == rs2) & (~use_imm | mem_write)));
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with operand forwarding and load-use stall.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_use_imm,
    input  logic [3:0]      id_alu_control,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            flush,
    input  logic            mem_fwd_en,
    input  logic            mem_fwd_is_load,
    input  logic [RA_W-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_en,
    input  logic [RA_W-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] alu_inp1,
    output logic [XLEN-1:0] alu_inp2,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write
);

    idex_t           q;
    idex_t           d_in;
    logic            v_q;
    fwd_sel_e        rs1_sel;
    fwd_sel_e        rs2_sel;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic            hazard;
    logic            fire_out;
    logic            accept;

    always_comb begin
        d_in             = '0;
        d_in.pc          = id_pc;
        d_in.rs1_data    = id_rs1_data;
        d_in.rs2_data    = id_rs2_data;
        d_in.imm         = id_imm;
        d_in.rs1         = id_rs1;
        d_in.rs2         = id_rs2;
        d_in.rd          = id_rd;
        d_in.use_imm     = id_use_imm;
        d_in.alu_control = id_alu_control;
        d_in.reg_write   = id_reg_write;
        d_in.mem_read    = id_mem_read;
        d_in.mem_write   = id_mem_write;
    end

    ex_forward_unit u_fwd (
        .valid           (v_q),
        .rs1             (q.rs1),
        .rs2             (q.rs2),
        .rs1_val         (q.rs1_data),
        .rs2_val         (q.rs2_data),
        .use_imm         (q.use_imm),
        .mem_write       (q.mem_write),
        .mem_fwd_en      (mem_fwd_en),
        .mem_fwd_is_load (mem_fwd_is_load),
        .mem_fwd_rd      (mem_fwd_rd),
        .mem_fwd_data    (mem_fwd_data),
        .wb_fwd_en       (wb_fwd_en),
        .wb_fwd_rd       (wb_fwd_rd),
        .wb_fwd_data     (wb_fwd_data),
        .rs1_sel         (rs1_sel),
        .rs2_sel         (rs2_sel),
        .rs1_fwd         (rs1_fwd),
        .rs2_fwd         (rs2_fwd),
        .hazard          (hazard)
    );

    always_comb begin
        ex_valid      = v_q & ~hazard & ~flush;
        fire_out      = ex_valid & ex_ready;
        id_ready      = ~v_q | fire_out;
        accept        = id_valid & id_ready;
        alu_inp1      = rs1_fwd;
        alu_inp2      = q.use_imm ? q.imm : rs2_fwd;
        ex_store_data = rs2_fwd;
        alu_control   = q.alu_control;
        ex_pc         = q.pc;
        ex_rd         = q.rd;
        ex_reg_write  = q.reg_write;
        ex_mem_read   = q.mem_read;
        ex_mem_write  = q.mem_write;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
            q   <= '0;
        end else if (flush) begin
            v_q <= 1'b0;
        end else if (accept) begin
            v_q <= 1'b1;
            q   <= d_in;
        end else if (fire_out) begin
            v_q <= 1'b0;
        end else if (v_q) begin
            // Capture forwarded results while held so they survive the producer retiring.
            if (rs1_sel != FWD_NONE) q.rs1_data <= rs1_fwd;
            if (rs2_sel != FWD_NONE) q.rs2_data <= rs2_fwd;
        end
    end

endmodule
`default_nettype wire
